mac_tile_reducer: RTL



---
 rtl/mac_tile_reducer_pkg.sv | 43 ++++
 rtl/mac_tile_reducer_if.sv | 29 ++
 rtl/mac_tile_reducer_row_sum_tree.sv | 16 +
 rtl/mac_tile_reducer.sv | 106 ++++++++++
 4 files changed

// File: rtl/mac_tile_reducer_pkg.sv
// Shared types and helpers for the MAC tile reducer: accumulator sizing,
// control states and the round/shift/saturate step applied to each lane.
package mac_reduce_pkg;

  // Widest lane total the requantizer accepts; totals are sign-extended to this width.
  localparam int SAT_IN_W = 64;

  typedef enum logic {
    ACCUM,
    FULL
  } state_t;

  function automatic int sum_width(input int acc_w, input int tile, input int cols);
    return acc_w + $clog2(tile) + $clog2(cols);
  endfunction

  // Round half up, arithmetic shift, then clamp to a signed data_w-bit range.
  function automatic logic signed [SAT_IN_W-1:0] sat_round(
    input  logic signed [SAT_IN_W-1:0] total,
    input  int                         shift,
    input  int                         data_w,
    output logic                       sat
  );
    logic signed [SAT_IN_W-1:0] rounded;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    logic signed [SAT_IN_W-1:0] result;
    rounded = (total + (SAT_IN_W'(1) <<< (shift - 1))) >>> shift;
    hi      = (SAT_IN_W'(1) <<< (data_w - 1)) - SAT_IN_W'(1);
    lo      = -(SAT_IN_W'(1) <<< (data_w - 1));
    sat     = 1'b0;
    result  = rounded;
    if (rounded > hi) begin
      result = hi;
      sat    = 1'b1;
    end else if (rounded < lo) begin
      result = lo;
      sat    = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_tile_reducer_if.sv
// Tile-in / vector-out handshake bundle of the MAC tile reducer.
interface mac_tile_reducer_if #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int COL_BLOCKS = 64
);
  localparam int CNT_W = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;

  logic                                           clear;
  logic                                           in_valid;
  logic                                           in_ready;
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] in_tile;
  logic                                           out_valid;
  logic                                           out_ready;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]           out_vec;
  logic [TILE_SIZE-1:0]                           out_sat;
  logic [CNT_W-1:0]                               beat_cnt;

  modport master (
    output clear, in_valid, in_tile, out_ready,
    input  in_ready, out_valid, out_vec, out_sat, beat_cnt
  );

  modport slave (
    input  clear, in_valid, in_tile, out_ready,
    output in_ready, out_valid, out_vec, out_sat, beat_cnt
  );
endinterface

// File: rtl/mac_tile_reducer_row_sum_tree.sv
// Combinational signed sum of one tile row, sign-extended to the accumulator width.
module row_sum_tree #(
  parameter int N     = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 40
) (
  input  logic [N-1:0][IN_W-1:0] elems,
  output logic signed [OUT_W-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int j = 0; j < N; j++) begin
      sum = sum + OUT_W'($signed(elems[j]));
    end
  end
endmodule

// File: rtl/mac_tile_reducer.sv
// Row-sums each incoming tile, accumulates COL_BLOCKS beats per lane and
// presents one requantized vector per tile on a valid/ready output.
module mac_tile_reducer
  import mac_reduce_pkg::*;
#(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int COL_BLOCKS = 64,
  parameter int OUT_SHIFT  = 8
) (
  input  logic            clk,
  input  logic            rst,
  mac_tile_reducer_if.slave bus
);
  localparam int SUM_WIDTH = sum_width(ACC_WIDTH, TILE_SIZE, COL_BLOCKS);
  localparam int CNT_W     = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COL_BLOCKS - 1);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic                         accept;
  logic signed [SUM_WIDTH-1:0]  rowsum_c  [TILE_SIZE];
  logic signed [SUM_WIDTH-1:0]  rowsum_p1 [TILE_SIZE];
  logic                         vld_p1;
  logic                         last_p1;
  logic signed [SUM_WIDTH-1:0]  acc_p2    [TILE_SIZE];
  logic signed [SUM_WIDTH-1:0]  total_c   [TILE_SIZE];
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_c;
  logic [TILE_SIZE-1:0]         sat_c;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_p2;
  logic [TILE_SIZE-1:0]         sat_p2;

  // A last beat sitting in S1 will flip the FSM to FULL next edge, so stop intake now.
  assign bus.in_ready  = (state == ACCUM) && !(vld_p1 && last_p1);
  assign accept        = bus.in_valid && bus.in_ready && !bus.clear;
  assign bus.out_valid = (state == FULL);
  assign bus.out_vec   = vec_p2;
  assign bus.out_sat   = sat_p2;
  assign bus.beat_cnt  = cnt;

  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_row
    row_sum_tree #(
      .N     (TILE_SIZE),
      .IN_W  (ACC_WIDTH),
      .OUT_W (SUM_WIDTH)
    ) u_row (
      .elems (bus.in_tile[i]),
      .sum   (rowsum_c[i])
    );
  end

  // S1: register row sums of the accepted beat and tag the tile's final beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      rowsum_p1 <= '{default: '0};
    end else if (bus.clear) begin
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1   <= (cnt == LAST_CNT);
        cnt       <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        rowsum_p1 <= rowsum_c;
      end
    end
  end

  always_comb begin
    vec_c = '0;
    sat_c = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      total_c[i] = acc_p2[i] + rowsum_p1[i];
      vec_c[i]   = DATA_WIDTH'(sat_round(SAT_IN_W'(total_c[i]), OUT_SHIFT, DATA_WIDTH, sat_c[i]));
    end
  end

  // S2: accumulate, retire the tile into the output register, and run the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ACCUM;
      acc_p2 <= '{default: '0};
      vec_p2 <= '0;
      sat_p2 <= '0;
    end else begin
      if (bus.clear) begin
        acc_p2 <= '{default: '0};
      end else if (vld_p1 && !last_p1) begin
        for (int i = 0; i < TILE_SIZE; i++) acc_p2[i] <= total_c[i];
      end else if (vld_p1 && last_p1) begin
        acc_p2 <= '{default: '0};
        vec_p2 <= vec_c;
        sat_p2 <= sat_c;
      end
      case (state)
        ACCUM:   if (vld_p1 && last_p1 && !bus.clear) state <= FULL;
        FULL:    if (bus.out_ready) state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
